// File: rtl/imem_fetch_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// imem_fetch_ctrl_pkg : instruction format, opcodes and fetch sequencer types
// Rev 1.0
// ============================================================================
package imem_fetch_ctrl_pkg;

  localparam int INSTR_MEM_DEPTH = 64;
  localparam int C_ADDR_W        = $clog2(INSTR_MEM_DEPTH);
  localparam int C_RD_LATENCY    = 0;

  // NA is encoded as zero so an unwritten memory word reads back as NA.
  typedef enum logic [3:0] {
    NA    = 4'd0,
    ADD   = 4'd1,
    SUB   = 4'd2,
    MUL   = 4'd3,
    SHIFT = 4'd4,
    XOR   = 4'd5,
    NOR   = 4'd6
  } opcode_e;

  typedef struct packed {
    opcode_e     opcode;
    logic [3:0]  rd;
    logic [3:0]  rs1;
    logic [3:0]  rs2;
    logic [15:0] imm;
  } instruction_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    DRAIN  = 2'd2,
    HALTED = 2'd3
  } fetch_state_e;

  typedef struct packed {
    logic [C_ADDR_W-1:0] pc;
    instruction_t        instr;
  } fetch_entry_t;

endpackage
`default_nettype wire

// File: rtl/imem_fetch_ctrl_if.sv
`default_nettype none
// ============================================================================
// imem_fetch_ctrl_if : instruction-memory read port plus decode handshake
// Rev 1.0
// ============================================================================
interface imem_fetch_ctrl_if #(
  parameter int ADDR_W = imem_fetch_ctrl_pkg::C_ADDR_W
);
  logic                              imem_re;
  logic [ADDR_W-1:0]                 imem_raddr;
  imem_fetch_ctrl_pkg::instruction_t imem_rdata;
  logic                              instr_valid;
  logic                              instr_ready;
  imem_fetch_ctrl_pkg::instruction_t instr_out;
  logic [ADDR_W-1:0]                 instr_pc;

  modport master (
    output imem_re, imem_raddr, instr_valid, instr_out, instr_pc,
    input  imem_rdata, instr_ready
  );

  modport slave (
    input  imem_re, imem_raddr, instr_valid, instr_out, instr_pc,
    output imem_rdata, instr_ready
  );
endinterface
`default_nettype wire

// File: rtl/imem_fetch_ctrl_fetch_buf.sv
`default_nettype none
// ============================================================================
// imem_fetch_ctrl_fetch_buf : synchronous FIFO of fetch entries with flush
// Rev 1.0
// ============================================================================
module imem_fetch_ctrl_fetch_buf
  import imem_fetch_ctrl_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  wire logic          clk,
  input  wire logic          resetn,
  input  wire logic          i_flush,
  input  wire logic          i_push,
  input  wire fetch_entry_t  i_data,
  input  wire logic          i_pop,
  output fetch_entry_t       o_data,
  output logic [CNT_W-1:0]   o_count,
  output logic               o_empty
);

  fetch_entry_t     r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_full;
  logic             w_do_pop;
  logic             w_do_push;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign w_full    = (r_count == CNT_W'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign w_do_pop  = i_pop & ~o_empty;
  // A push into a full buffer is legal when the head leaves in the same cycle.
  assign w_do_push = i_push & (~w_full | w_do_pop);
  assign o_data    = o_empty ? '0 : r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_do_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/imem_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// imem_fetch_ctrl : fetch PC sequencer with latency-absorbing output buffer
// Rev 1.0
// ============================================================================
module imem_fetch_ctrl
  import imem_fetch_ctrl_pkg::*;
#(
  parameter int RD_LATENCY = C_RD_LATENCY,
  parameter int BUF_DEPTH  = 2,
  parameter int ADDR_W     = C_ADDR_W
) (
  input  wire logic              clk,
  input  wire logic              resetn,
  input  wire logic              i_start,
  input  wire logic [ADDR_W-1:0] i_start_addr,
  input  wire logic              i_redirect_valid,
  input  wire logic [ADDR_W-1:0] i_redirect_addr,
  output logic                   o_busy,
  output logic                   o_halted,
  imem_fetch_ctrl_if.master      bus
);

  localparam int CNT_W = $clog2(BUF_DEPTH + 1);

  fetch_state_e      r_state;
  logic [ADDR_W-1:0] r_pc;
  logic              r_epoch;
  logic              r_busy;
  logic              r_halted;

  logic [CNT_W-1:0]  w_count;
  logic              w_empty;
  logic [CNT_W:0]    w_level;
  fetch_entry_t      w_head;
  fetch_entry_t      w_push_entry;
  logic              w_pop, w_issue, w_push, w_redirect, w_start_ok;
  logic              w_ret_fire, w_ret_epoch, w_ret_pending, w_ret_ok, w_ret_na;
  logic [ADDR_W-1:0] w_ret_pc;
  logic [ADDR_W-1:0] w_start_pc;
  logic [ADDR_W-1:0] w_redirect_pc;

  assign w_start_pc    = i_start_addr & ~ADDR_W'(3);
  assign w_redirect_pc = i_redirect_addr & ~ADDR_W'(3);
  assign w_pop         = ~w_empty & bus.instr_ready;
  assign w_redirect    = i_redirect_valid & ((r_state == RUN) | (r_state == DRAIN));
  assign w_start_ok    = i_start & ((r_state == IDLE) | (r_state == HALTED));
  assign w_level       = {1'b0, w_count} + (CNT_W+1)'(w_ret_pending) - (CNT_W+1)'(w_pop);
  assign w_issue       = (r_state == RUN) & (w_level < (CNT_W+1)'(BUF_DEPTH));

  // Returns count only in RUN with a matching epoch, so anything younger than an
  // NA or older than a redirect is dropped without touching the buffer.
  assign w_ret_ok      = w_ret_fire & (w_ret_epoch == r_epoch) & (r_state == RUN) & ~w_redirect;
  assign w_ret_na      = w_ret_ok & (bus.imem_rdata.opcode == NA);
  assign w_push        = w_ret_ok & ~w_ret_na;
  assign w_push_entry  = '{pc: w_ret_pc, instr: bus.imem_rdata};

  generate
    if (RD_LATENCY == 0) begin : g_lat0
      assign w_ret_fire    = w_issue;
      assign w_ret_pc      = r_pc;
      assign w_ret_epoch   = r_epoch;
      assign w_ret_pending = 1'b0;
    end else begin : g_lat1
      logic              r_infl_vld;
      logic              r_infl_epoch;
      logic [ADDR_W-1:0] r_infl_pc;

      always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
          r_infl_vld   <= 1'b0;
          r_infl_epoch <= 1'b0;
          r_infl_pc    <= '0;
        end else begin
          r_infl_vld   <= w_issue;
          r_infl_epoch <= r_epoch;
          r_infl_pc    <= r_pc;
        end
      end

      assign w_ret_fire    = r_infl_vld;
      assign w_ret_pc      = r_infl_pc;
      assign w_ret_epoch   = r_infl_epoch;
      assign w_ret_pending = r_infl_vld;
    end
  endgenerate

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state  <= IDLE;
      r_pc     <= '0;
      r_epoch  <= 1'b0;
      r_busy   <= 1'b0;
      r_halted <= 1'b0;
    end else begin
      if (w_issue) r_pc <= r_pc + ADDR_W'(4);
      case (r_state)
        IDLE, HALTED: begin
          if (w_start_ok) begin
            r_state  <= RUN;
            r_pc     <= w_start_pc;
            r_busy   <= 1'b1;
            r_halted <= 1'b0;
          end
        end
        RUN: begin
          if (w_redirect) begin
            r_pc    <= w_redirect_pc;
            r_epoch <= ~r_epoch;
          end else if (w_ret_na) begin
            r_state <= DRAIN;
          end
        end
        DRAIN: begin
          if (w_redirect) begin
            r_state <= RUN;
            r_pc    <= w_redirect_pc;
            r_epoch <= ~r_epoch;
          end else if (w_empty) begin
            r_state  <= HALTED;
            r_busy   <= 1'b0;
            r_halted <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  imem_fetch_ctrl_fetch_buf #(
    .DEPTH (BUF_DEPTH)
  ) u_buf (
    .clk     (clk),
    .resetn  (resetn),
    .i_flush (w_redirect),
    .i_push  (w_push),
    .i_data  (w_push_entry),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_count (w_count),
    .o_empty (w_empty)
  );

  assign bus.imem_re     = w_issue;
  assign bus.imem_raddr  = r_pc;
  assign bus.instr_valid = ~w_empty;
  assign bus.instr_out   = w_head.instr;
  assign bus.instr_pc    = w_head.pc;
  assign o_busy          = r_busy;
  assign o_halted        = r_halted;

endmodule
`default_nettype wire

// File: tb/tb_imem_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// tb_imem_fetch_ctrl : scoreboard bench for the fetch sequencer (RD_LATENCY=1)
// Rev 1.0
// ============================================================================
module tb_imem_fetch_ctrl;
  import imem_fetch_ctrl_pkg::*;

  localparam int AW = C_ADDR_W;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] start_addr = '0;
  logic          redirect_valid = 1'b0;
  logic [AW-1:0] redirect_addr = '0;
  logic          busy, halted;

  int n_total = 0;
  int n_bad   = 0;

  instruction_t mem [16];
  fetch_entry_t exp_q [$];

  imem_fetch_ctrl_if #(.ADDR_W(AW)) bus ();

  imem_fetch_ctrl #(
    .RD_LATENCY (1),
    .BUF_DEPTH  (2),
    .ADDR_W     (AW)
  ) dut (
    .clk              (clk),
    .resetn           (resetn),
    .i_start          (start),
    .i_start_addr     (start_addr),
    .i_redirect_valid (redirect_valid),
    .i_redirect_addr  (redirect_addr),
    .o_busy           (busy),
    .o_halted         (halted),
    .bus              (bus)
  );

  always #5 clk = ~clk;

  // Registered read port gated by re
  always @(posedge clk) begin
    if (bus.imem_re) bus.imem_rdata <= mem[bus.imem_raddr[AW-1:2]];
  end

  function automatic instruction_t mk(input opcode_e op, input int rd, input int rs1, input int rs2);
    instruction_t i;
    i = '0;
    i.opcode = op;
    i.rd  = 4'(rd);
    i.rs1 = 4'(rs1);
    i.rs2 = 4'(rs2);
    return i;
  endfunction

  function automatic fetch_entry_t ent(input int pc, input instruction_t ins);
    fetch_entry_t e;
    e.pc    = AW'(pc);
    e.instr = ins;
    return e;
  endfunction

  // Scoreboard: every accepted head must match the oldest expected entry
  always @(negedge clk) begin
    if (resetn && bus.instr_valid && bus.instr_ready) begin
      n_total++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL sb_unexpected got pc=%0d op=%0d required nothing", bus.instr_pc, bus.instr_out.opcode);
      end else begin
        fetch_entry_t e;
        e = exp_q.pop_front();
        if (bus.instr_pc !== e.pc || bus.instr_out !== e.instr) begin
          n_bad++;
          $display("FAIL sb_entry got pc=%0d instr=%h required pc=%0d instr=%h",
                   bus.instr_pc, bus.instr_out, e.pc, e.instr);
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input int a);
    cyc();
    start      = 1'b1;
    start_addr = AW'(a);
    cyc();
    start      = 1'b0;
  endtask

  task automatic wait_halted(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (halted) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic push_program();
    exp_q.push_back(ent(0,  mk(MUL, 3, 2, 1)));
    exp_q.push_back(ent(4,  mk(SHIFT, 6, 5, 4)));
    exp_q.push_back(ent(8,  mk(XOR, 9, 8, 7)));
    exp_q.push_back(ent(12, mk(NOR, 13, 11, 10)));
  endtask

  task automatic test_reset();
    #2;
    n_total += 7;
    if (bus.imem_re !== 1'b0)    begin n_bad++; $display("FAIL rst_re got=%b required=0", bus.imem_re); end
    if (bus.imem_raddr !== '0)   begin n_bad++; $display("FAIL rst_raddr got=%0d required=0", bus.imem_raddr); end
    if (bus.instr_valid !== 1'b0) begin n_bad++; $display("FAIL rst_valid got=%b required=0", bus.instr_valid); end
    if (bus.instr_out !== '0)    begin n_bad++; $display("FAIL rst_out got=%h required=0", bus.instr_out); end
    if (bus.instr_pc !== '0)     begin n_bad++; $display("FAIL rst_pc got=%0d required=0", bus.instr_pc); end
    if (busy !== 1'b0)           begin n_bad++; $display("FAIL rst_busy got=%b required=0", busy); end
    if (halted !== 1'b0)         begin n_bad++; $display("FAIL rst_halted got=%b required=0", halted); end
    @(negedge clk);
    resetn = 1'b1;
  endtask

  task automatic test_sequential();
    int  first, last, nv, nre;
    bit  done;
    first = -1; last = -1; nv = 0; nre = 0; done = 1'b0;
    bus.instr_ready = 1'b1;
    push_program();
    pulse_start(0);
    for (int k = 0; k < 40 && !done; k++) begin
      @(negedge clk);
      if (bus.instr_valid) begin
        nv++;
        if (first < 0) first = k;
        last = k;
      end
      if (halted) done = 1'b1;
    end
    n_total += 6;
    if (!done)              begin n_bad++; $display("FAIL seq_halt_timeout got=0 required=1"); end
    if (nv != 4)            begin n_bad++; $display("FAIL seq_valid_count got=%0d required=4", nv); end
    if (last - first != 3)  begin n_bad++; $display("FAIL seq_throughput got span=%0d required=3", last - first); end
    if (busy !== 1'b0)      begin n_bad++; $display("FAIL seq_busy got=%b required=0", busy); end
    if (halted !== 1'b1)    begin n_bad++; $display("FAIL seq_halted got=%b required=1", halted); end
    if (exp_q.size() != 0)  begin n_bad++; $display("FAIL seq_leftover got=%0d required=0", exp_q.size()); end
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (bus.imem_re) nre++;
    end
    n_total++;
    if (nre != 0) begin n_bad++; $display("FAIL seq_re_after_halt got=%0d required=0", nre); end
  endtask

  task automatic test_backpressure();
    int issued, popped, maxo;
    issued = 0; popped = 0; maxo = 0;
    bus.instr_ready = 1'b1;
    push_program();
    pulse_start(0);
    for (int k = 0; k < 60; k++) begin
      bus.instr_ready = !(k >= 2 && k <= 5);
      @(negedge clk);
      if (bus.imem_re && bus.imem_raddr < AW'(16)) issued++;
      if (bus.instr_valid && bus.instr_ready) popped++;
      if (issued - popped > maxo) maxo = issued - popped;
      if (k >= 2 && k <= 5) begin
        n_total++;
        if (bus.instr_valid !== 1'b1 || bus.instr_pc !== AW'(0) || bus.instr_out !== mk(MUL, 3, 2, 1)) begin
          n_bad++;
          $display("FAIL bp_head_stable k=%0d got v=%b pc=%0d instr=%h required v=1 pc=0 MUL",
                   k, bus.instr_valid, bus.instr_pc, bus.instr_out);
        end
      end
      if (halted) break;
      @(posedge clk);
      #1;
    end
    bus.instr_ready = 1'b1;
    n_total += 3;
    if (maxo > 2)          begin n_bad++; $display("FAIL bp_occupancy got=%0d required<=2", maxo); end
    if (halted !== 1'b1)   begin n_bad++; $display("FAIL bp_halted got=%b required=1", halted); end
    if (exp_q.size() != 0) begin n_bad++; $display("FAIL bp_leftover got=%0d required=0", exp_q.size()); end
  endtask

  task automatic test_redirect();
    bit ok;
    bus.instr_ready = 1'b1;
    pulse_start(0);
    cyc();
    n_total++;
    if (bus.imem_re !== 1'b1 || bus.imem_raddr !== AW'(4)) begin
      n_bad++; $display("FAIL rd_issue4 got re=%b addr=%0d required re=1 addr=4", bus.imem_re, bus.imem_raddr);
    end
    redirect_valid = 1'b1;
    redirect_addr  = AW'(8);
    exp_q.push_back(ent(8,  mk(XOR, 9, 8, 7)));
    exp_q.push_back(ent(12, mk(NOR, 13, 11, 10)));
    cyc();
    redirect_valid = 1'b0;
    n_total += 2;
    if (bus.imem_re !== 1'b1 || bus.imem_raddr !== AW'(8)) begin
      n_bad++; $display("FAIL rd_first_new got re=%b addr=%0d required re=1 addr=8", bus.imem_re, bus.imem_raddr);
    end
    if (bus.instr_valid !== 1'b0) begin n_bad++; $display("FAIL rd_flush_valid got=%b required=0", bus.instr_valid); end
    wait_halted(40, ok);
    n_total += 2;
    if (!ok)               begin n_bad++; $display("FAIL rd_halt_timeout got=0 required=1"); end
    if (exp_q.size() != 0) begin n_bad++; $display("FAIL rd_leftover got=%0d required=0", exp_q.size()); end
  endtask

  task automatic test_unaligned();
    bit ok;
    bus.instr_ready = 1'b1;
    exp_q.push_back(ent(12, mk(NOR, 13, 11, 10)));
    pulse_start(14);
    n_total++;
    if (bus.imem_re !== 1'b1 || bus.imem_raddr !== AW'(12)) begin
      n_bad++; $display("FAIL ua_first_addr got re=%b addr=%0d required re=1 addr=12", bus.imem_re, bus.imem_raddr);
    end
    wait_halted(40, ok);
    n_total += 2;
    if (!ok)               begin n_bad++; $display("FAIL ua_halt_timeout got=0 required=1"); end
    if (exp_q.size() != 0) begin n_bad++; $display("FAIL ua_leftover got=%0d required=0", exp_q.size()); end
  endtask

  task automatic test_wrap();
    bit ok;
    bus.instr_ready = 1'b1;
    exp_q.push_back(ent(60, mk(ADD, 1, 1, 1)));
    push_program();
    pulse_start(60);
    n_total++;
    if (bus.imem_re !== 1'b1 || bus.imem_raddr !== AW'(60)) begin
      n_bad++; $display("FAIL wr_addr60 got re=%b addr=%0d required re=1 addr=60", bus.imem_re, bus.imem_raddr);
    end
    cyc();
    n_total++;
    if (bus.imem_re !== 1'b1 || bus.imem_raddr !== AW'(0)) begin
      n_bad++; $display("FAIL wr_addr0 got re=%b addr=%0d required re=1 addr=0", bus.imem_re, bus.imem_raddr);
    end
    wait_halted(40, ok);
    n_total += 2;
    if (!ok)               begin n_bad++; $display("FAIL wr_halt_timeout got=0 required=1"); end
    if (exp_q.size() != 0) begin n_bad++; $display("FAIL wr_leftover got=%0d required=0", exp_q.size()); end
  endtask

  task automatic test_async_reset();
    bit ok;
    bus.instr_ready = 1'b0;
    pulse_start(0);
    cyc();
    cyc();
    n_total++;
    if (bus.instr_valid !== 1'b1) begin n_bad++; $display("FAIL ar_precond_valid got=%b required=1", bus.instr_valid); end
    #2;
    resetn = 1'b0;
    #1;
    n_total += 7;
    if (bus.imem_re !== 1'b0)     begin n_bad++; $display("FAIL ar_re got=%b required=0", bus.imem_re); end
    if (bus.imem_raddr !== '0)    begin n_bad++; $display("FAIL ar_raddr got=%0d required=0", bus.imem_raddr); end
    if (bus.instr_valid !== 1'b0) begin n_bad++; $display("FAIL ar_valid got=%b required=0", bus.instr_valid); end
    if (bus.instr_out !== '0)     begin n_bad++; $display("FAIL ar_out got=%h required=0", bus.instr_out); end
    if (bus.instr_pc !== '0)      begin n_bad++; $display("FAIL ar_pc got=%0d required=0", bus.instr_pc); end
    if (busy !== 1'b0)            begin n_bad++; $display("FAIL ar_busy got=%b required=0", busy); end
    if (halted !== 1'b0)          begin n_bad++; $display("FAIL ar_halted got=%b required=0", halted); end
    @(posedge clk);
    #3;
    resetn = 1'b1;
    bus.instr_ready = 1'b1;
    push_program();
    pulse_start(0);
    wait_halted(40, ok);
    n_total += 2;
    if (!ok)               begin n_bad++; $display("FAIL ar_halt_timeout got=0 required=1"); end
    if (exp_q.size() != 0) begin n_bad++; $display("FAIL ar_leftover got=%0d required=0", exp_q.size()); end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = '0;
    mem[0]  = mk(MUL, 3, 2, 1);
    mem[1]  = mk(SHIFT, 6, 5, 4);
    mem[2]  = mk(XOR, 9, 8, 7);
    mem[3]  = mk(NOR, 13, 11, 10);
    mem[15] = mk(ADD, 1, 1, 1);
    bus.instr_ready = 1'b0;

    test_reset();
    test_sequential();
    test_backpressure();
    test_redirect();
    test_unaligned();
    test_wrap();
    test_async_reset();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
